// File: rtl/mul_hash_pkg.sv
// Constants and helpers shared by mul_hash and its consumers. Keeping the
// latency here keeps the producer and consumer delay depths in step.
package mul_hash_pkg;

   localparam logic [63:0] MUL_HASH_B      = 64'h0b4e0ef37bc32127;
   localparam int          MUL_HASH_LAT    = 6;
   localparam int          MUL_HASH_TERM_W = 24;
   localparam int          MUL_HASH_PROD_W = 64;

   typedef enum logic [0:0] {
      ACC_IDLE  = 1'b0,
      ACC_ACCUM = 1'b1
   } acc_state_e;

   function automatic logic [MUL_HASH_PROD_W-1:0] rotl1(input logic [MUL_HASH_PROD_W-1:0] x);
      return {x[MUL_HASH_PROD_W-2:0], x[MUL_HASH_PROD_W-1]};
   endfunction

endpackage

// File: rtl/mul_hash_combine.sv
// Recombines the four 24-bit partial products of one byte into the 64-bit
// product and registers it together with its framing bits.
module mul_hash_combine
   import mul_hash_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       in_last,
   input  logic [MUL_HASH_TERM_W-1:0] ab0,
   input  logic [MUL_HASH_TERM_W-1:0] ab1,
   input  logic [MUL_HASH_TERM_W-1:0] ab2,
   input  logic [MUL_HASH_TERM_W-1:0] ab3,
   output logic                       p_valid,
   output logic                       p_last,
   output logic [MUL_HASH_PROD_W-1:0] p
);

   logic [MUL_HASH_PROD_W-1:0] sum_s;

   // Shift-add of the terms; carries past bit 63 and the top of ab3 fall off.
   always_comb begin
      sum_s = MUL_HASH_PROD_W'(ab0)
            + (MUL_HASH_PROD_W'(ab1) << 6'd16)
            + (MUL_HASH_PROD_W'(ab2) << 6'd32)
            + (MUL_HASH_PROD_W'(ab3) << 6'd48);
   end

   // Product register with its valid/last bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_valid <= 1'b0;
         p_last  <= 1'b0;
         p       <= {MUL_HASH_PROD_W{1'b0}};
      end else begin
         p_valid <= in_valid;
         p_last  <= in_valid & in_last;
         p       <= sum_s;
      end
   end

endmodule

// File: rtl/mul_hash_acc.sv
// Folds mul_hash byte products into a rolling per-string hash and emits one
// hash with its length per string (or per MAX_LEN bytes when truncated).
module mul_hash_acc
   import mul_hash_pkg::*;
#(
   parameter int HASH_BITS = 16,
   parameter int MAX_LEN   = 32,
   parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       in_last,
   input  logic [MUL_HASH_TERM_W-1:0] ab0,
   input  logic [MUL_HASH_TERM_W-1:0] ab1,
   input  logic [MUL_HASH_TERM_W-1:0] ab2,
   input  logic [MUL_HASH_TERM_W-1:0] ab3,
   output logic                       out_valid,
   output logic [HASH_BITS-1:0]       out_hash,
   output logic [LEN_W-1:0]           out_len,
   output logic                       out_trunc,
   output logic                       busy
);

   logic [MUL_HASH_LAT-1:0]    v_dly_r;
   logic [MUL_HASH_LAT-1:0]    l_dly_r;
   logic                       p_valid_s;
   logic                       p_last_s;
   logic [MUL_HASH_PROD_W-1:0] p_s;
   acc_state_e                 state_r;
   logic [MUL_HASH_PROD_W-1:0] acc_r;
   logic [LEN_W-1:0]           cnt_r;
   logic [MUL_HASH_PROD_W-1:0] acc_next_s;
   logic [LEN_W-1:0]           cnt_next_s;
   logic                       at_limit_s;
   logic                       close_s;

   // Framing delay line; the oldest stage lines up with ab0..ab3.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_dly_r <= {MUL_HASH_LAT{1'b0}};
         l_dly_r <= {MUL_HASH_LAT{1'b0}};
      end else begin
         v_dly_r <= {v_dly_r[MUL_HASH_LAT-2:0], in_valid};
         l_dly_r <= {l_dly_r[MUL_HASH_LAT-2:0], in_valid & in_last};
      end
   end

   mul_hash_combine u_combine (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v_dly_r[MUL_HASH_LAT-1]),
      .in_last  (l_dly_r[MUL_HASH_LAT-1]),
      .ab0      (ab0),
      .ab1      (ab1),
      .ab2      (ab2),
      .ab3      (ab3),
      .p_valid  (p_valid_s),
      .p_last   (p_last_s),
      .p        (p_s)
   );

   // Next accumulator/count; a closed string restarts from zero with no bubble.
   always_comb begin
      acc_next_s = {MUL_HASH_PROD_W{1'b0}};
      cnt_next_s = {LEN_W{1'b0}};
      if (state_r == ACC_ACCUM) begin
         acc_next_s = rotl1(acc_r) ^ p_s;
         cnt_next_s = cnt_r + LEN_W'(1);
      end else begin
         acc_next_s = p_s;
         cnt_next_s = LEN_W'(1);
      end
      at_limit_s = (cnt_next_s == LEN_W'(MAX_LEN));
      close_s    = p_last_s | at_limit_s;
   end

   // String FSM with registered emit outputs; gaps leave acc/cnt untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ACC_IDLE;
         acc_r     <= {MUL_HASH_PROD_W{1'b0}};
         cnt_r     <= {LEN_W{1'b0}};
         out_valid <= 1'b0;
         out_hash  <= {HASH_BITS{1'b0}};
         out_len   <= {LEN_W{1'b0}};
         out_trunc <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (p_valid_s) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            if (close_s) begin
               state_r   <= ACC_IDLE;
               out_valid <= 1'b1;
               out_hash  <= acc_next_s[MUL_HASH_PROD_W-1 -: HASH_BITS];
               out_len   <= cnt_next_s;
               out_trunc <= at_limit_s & ~p_last_s;
            end else begin
               state_r <= ACC_ACCUM;
            end
         end
      end
   end

   // Busy while a string is open or any byte is still in the pipeline.
   always_comb begin
      busy = (state_r == ACC_ACCUM) | (|v_dly_r) | p_valid_s;
   end

endmodule

// File: tb/tb_mul_hash_acc.sv
// Directed bench for mul_hash_acc: a behavioural mul_hash (byte * B split into
// four 16-bit slices, 6-cycle latency) feeds the DUT; emits are queued and checked.
module tb_mul_hash_acc;
   import mul_hash_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic [7:0]  a_in;
   logic [23:0] ab0, ab1, ab2, ab3;
   logic        out_valid;
   logic [15:0] out_hash;
   logic [2:0]  out_len;
   logic        out_trunc;
   logic        busy;

   typedef struct packed {
      int          cyc;
      logic [15:0] h;
      logic [2:0]  len;
      logic        trunc;
   } emit_t;

   emit_t emits[$];
   int    cyc     = 0;
   int    n_check = 0;
   int    n_fail  = 0;

   logic [23:0] pipe [6][4];

   mul_hash_acc #(.HASH_BITS(16), .MAX_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .ab0       (ab0),
      .ab1       (ab1),
      .ab2       (ab2),
      .ab3       (ab3),
      .out_valid (out_valid),
      .out_hash  (out_hash),
      .out_len   (out_len),
      .out_trunc (out_trunc),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] term(input logic [7:0] a, input int k);
      logic [63:0] b;
      b = MUL_HASH_B;
      return 24'(a) * 24'(b[16*k +: 16]);
   endfunction

   // Upstream mul_hash stand-in: terms appear 6 cycles after the byte.
   always @(posedge clk) begin
      for (int i = 5; i > 0; i--)
         for (int k = 0; k < 4; k++)
            pipe[i][k] <= pipe[i-1][k];
      for (int k = 0; k < 4; k++)
         pipe[0][k] <= in_valid ? term(a_in, k) : 24'h0;
   end

   assign ab0 = pipe[5][0];
   assign ab1 = pipe[5][1];
   assign ab2 = pipe[5][2];
   assign ab3 = pipe[5][3];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_check++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid === 1'b1)
         emits.push_back('{cyc: cyc, h: out_hash, len: out_len, trunc: out_trunc});
   endtask

   task automatic send(input logic [7:0] a, input logic last);
      in_valid = 1'b1;
      in_last  = last;
      a_in     = a;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      a_in     = 8'h00;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic expect_emit(input string tag, input logic [15:0] h, input logic [2:0] len,
                              input logic trunc, output int cyc_o);
      emit_t e;
      cyc_o = -1;
      if (emits.size() == 0) begin
         check_eq({tag, "_present"}, 64'd0, 64'd1);
      end else begin
         e = emits.pop_front();
         cyc_o = e.cyc;
         check_eq({tag, "_hash"},  64'(e.h),     64'(h));
         check_eq({tag, "_len"},   64'(e.len),   64'(len));
         check_eq({tag, "_trunc"}, 64'(e.trunc), 64'(trunc));
      end
   endtask

   initial begin
      int t0;
      int c1;
      int c2;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      a_in     = 8'h00;
      repeat (3) tick();
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_hash",  64'(out_hash),  64'd0);
      check_eq("rst_out_len",   64'(out_len),   64'd0);
      check_eq("rst_out_trunc", 64'(out_trunc), 64'd0);
      check_eq("rst_busy",      64'(busy),      64'd0);
      rst = 1'b0;
      idle(2);

      // single byte, latency 8
      t0 = cyc;
      send(8'h01, 1'b1);
      check_eq("busy_inflight", 64'(busy), 64'd1);
      idle(12);
      expect_emit("single", 16'h0b4e, 3'd1, 1'b0, c1);
      check_eq("single_latency", 64'(c1 - t0), 64'd8);
      check_eq("busy_after", 64'(busy), 64'd0);

      // two bytes
      send(8'h01, 1'b0);
      send(8'h01, 1'b1);
      idle(12);
      expect_emit("two", 16'h1dd2, 3'd2, 1'b0, c1);

      // zero byte then back-to-back single byte
      send(8'h00, 1'b1);
      send(8'h01, 1'b1);
      idle(12);
      expect_emit("zero", 16'h0000, 3'd1, 1'b0, c1);
      expect_emit("b2b",  16'h0b4e, 3'd1, 1'b0, c2);
      check_eq("b2b_spacing", 64'(c2 - c1), 64'd1);

      // forced emit at MAX_LEN=4, remainder hashed fresh
      for (int i = 0; i < 6; i++)
         send(8'h01, (i == 5) ? 1'b1 : 1'b0);
      idle(12);
      expect_emit("forced",  16'h6a9a, 3'd4, 1'b1, c1);
      expect_emit("remnant", 16'h1dd2, 3'd2, 1'b0, c2);
      check_eq("remnant_spacing", 64'(c2 - c1), 64'd2);

      // gap inside string, last on the limit byte
      send(8'h01, 1'b0);
      send(8'h01, 1'b0);
      idle(3);
      send(8'h01, 1'b0);
      send(8'h01, 1'b1);
      idle(12);
      expect_emit("gap", 16'h6a9a, 3'd4, 1'b0, c1);
      check_eq("hold_hash", 64'(out_hash), 64'h6a9a);
      check_eq("hold_len",  64'(out_len),  64'd4);

      // reset while a string is in flight
      send(8'h01, 1'b0);
      send(8'h01, 1'b0);
      send(8'h01, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rstmid_out_valid", 64'(out_valid), 64'd0);
      check_eq("rstmid_busy",      64'(busy),      64'd0);
      t0 = cyc;
      send(8'h01, 1'b1);
      idle(12);
      expect_emit("post_rst", 16'h0b4e, 3'd1, 1'b0, c1);
      check_eq("post_rst_latency", 64'(c1 - t0), 64'd8);
      check_eq("no_extra_emits", 64'(emits.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
      $finish;
   end

endmodule
